ram_bus_controller: RTL and testbench

//  Upstream master for the 28-bit-address, 16-bit-data large sync RAM.

---
 rtl/ram_bus_controller_if.sv | 26 ++
 rtl/ram_bus_controller.sv | 134 +++++++++++++
 tb/tb_ram_bus_controller.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bus_controller_if.sv
// rtl/ram_bus_controller_if.sv - request/response handshake bundle for ram_bus_controller
interface ram_bus_controller_if #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 4
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [LEN_WIDTH-1:0]  req_len;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_last;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_len,
      input  req_ready, rsp_valid, rsp_rdata, rsp_last
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_len,
      output req_ready, rsp_valid, rsp_rdata, rsp_last
   );
endinterface

// File: rtl/ram_bus_controller.sv
// rtl/ram_bus_controller.sv - sync-RAM bus master with read turnaround
// MEMCTL_BURST_EN enables multi-beat reads driven by req_len.
module ram_bus_controller #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   ram_bus_controller_if.slave   req_if,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   inout  wire  [DATA_WIDTH-1:0] ram_data_io,
   output logic                  ram_cs_o,
   output logic                  ram_we_o,
   output logic                  ram_oe_o,
   output logic                  busy_o
);
   typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, TURN} state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] ram_addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  drive_q;
   logic                  ram_cs_q;
   logic                  ram_we_q;
   logic                  ram_oe_q;
   logic                  req_ready_q;
   logic                  busy_q;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic                  rsp_last_q;
`ifdef MEMCTL_BURST_EN
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  beat_q;
`else
   logic                  unused_len;
   assign unused_len = ^req_if.req_len;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         ram_addr_q  <= '0;
         wdata_q     <= '0;
         drive_q     <= 1'b0;
         ram_cs_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_oe_q    <= 1'b0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_last_q  <= 1'b0;
`ifdef MEMCTL_BURST_EN
         len_q       <= '0;
         beat_q      <= '0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_if.req_valid) begin
                  ram_addr_q  <= req_if.req_addr;
                  ram_cs_q    <= 1'b1;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (req_if.req_we) begin
                     state_q  <= WR;
                     ram_we_q <= 1'b1;
                     drive_q  <= 1'b1;
                     wdata_q  <= req_if.req_wdata;
                  end else begin
                     state_q  <= RD_ADDR;
                     ram_oe_q <= 1'b1;
`ifdef MEMCTL_BURST_EN
                     len_q    <= req_if.req_len;
                     beat_q   <= '0;
`endif
                  end
               end
            end
            WR: begin
               state_q     <= IDLE;
               ram_cs_q    <= 1'b0;
               ram_we_q    <= 1'b0;
               drive_q     <= 1'b0;
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            RD_ADDR: state_q <= RD_DATA;
            RD_DATA: begin
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= ram_data_io;
`ifdef MEMCTL_BURST_EN
               rsp_last_q  <= (beat_q == len_q);
               if (beat_q != len_q) begin
                  // Address wraps naturally at the top of the RAM.
                  beat_q     <= beat_q + 1'b1;
                  ram_addr_q <= ram_addr_q + 1'b1;
                  state_q    <= RD_ADDR;
               end else begin
                  state_q  <= TURN;
                  ram_cs_q <= 1'b0;
                  ram_oe_q <= 1'b0;
               end
`else
               rsp_last_q  <= 1'b1;
               state_q     <= TURN;
               ram_cs_q    <= 1'b0;
               ram_oe_q    <= 1'b0;
`endif
            end
            TURN: begin
               // Dead cycle so the RAM releases the data bus before any write.
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ram_data_io      = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};
   assign ram_addr_o       = ram_addr_q;
   assign ram_cs_o         = ram_cs_q;
   assign ram_we_o         = ram_we_q;
   assign ram_oe_o         = ram_oe_q;
   assign busy_o           = busy_q;
   assign req_if.req_ready = req_ready_q;
   assign req_if.rsp_valid = rsp_valid_q;
   assign req_if.rsp_rdata = rsp_rdata_q;
   assign req_if.rsp_last  = rsp_last_q;
endmodule

// File: tb/tb_ram_bus_controller.sv
// tb/tb_ram_bus_controller.sv - randomized scoreboard bench for ram_bus_controller
module tb_ram_bus_controller;
   localparam int AW = 28;
   localparam int DW = 16;
   localparam int LW = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic [31:0]   due;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ram_bus_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();
   logic [AW-1:0] ram_addr;
   wire  [DW-1:0] ram_data;
   logic          ram_cs, ram_we, ram_oe, busy;

   ram_bus_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .req_if(bus),
      .ram_addr_o(ram_addr), .ram_data_io(ram_data),
      .ram_cs_o(ram_cs), .ram_we_o(ram_we), .ram_oe_o(ram_oe), .busy_o(busy)
   );

   int unsigned nvec = 0;
   int unsigned nerr = 0;
   logic [31:0] cyc = 0;
   logic [31:0] next_ok = 0;
   logic        gap = 1'b1;
   exp_t        exp_q[$];

   logic [DW-1:0] ram_mem [logic [AW-1:0]];
   logic [DW-1:0] ref_mem [logic [AW-1:0]];
   logic [DW-1:0] rd_val = '0;

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return a[15:0] ^ {4'h0, a[27:16]} ^ 16'hC3A5;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      nvec++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, expv, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc <= cyc + 1;
   end

   // RAM behavioural model: write on edge, combinational read drive
   initial forever begin
      @(posedge clk);
      if (ram_cs && ram_we) ram_mem[ram_addr] = ram_data;
   end
   initial forever begin
      @(negedge clk);
      rd_val = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : dflt(ram_addr);
   end
   assign ram_data = (ram_cs && ram_oe && !ram_we) ? rd_val : {DW{1'bz}};

   // Monitor / scoreboard
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_n) begin
         chk("we_oe_exclusive", 32'(ram_we && ram_oe), 32'd0);
         chk("busy_vs_ready", 32'(busy), 32'(!bus.req_ready));
         if (bus.rsp_valid) begin
            if (exp_q.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
            else begin
               e = exp_q.pop_front();
               chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.data));
               chk("rsp_last", 32'(bus.rsp_last), 32'(e.last));
               chk("rsp_cycle", cyc, e.due);
            end
         end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
            e = exp_q.pop_front();
            chk("rsp_late", cyc, e.due);
         end
      end
   end

   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [LW-1:0] len);
      int n;
      int w;
      logic [31:0]   acc;
      logic [AW-1:0] ak;
      exp_t          e;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_len   = len;
      w = 0;
      while (!bus.req_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (!bus.req_ready) begin
         chk("req_accept_timeout", 32'd0, 32'd1);
         bus.req_valid = 1'b0;
         gap = 1'b1;
         return;
      end
      acc = cyc + 1;
      if (!gap) chk("accept_cycle", acc, next_ok);
      if (we) begin
         ref_mem[a] = d;
         next_ok = acc + 2;
      end else begin
`ifdef MEMCTL_BURST_EN
         n = int'(len) + 1;
`else
         n = 1;
`endif
         for (int k = 0; k < n; k++) begin
            ak     = a + AW'(k);
            e.data = ref_mem.exists(ak) ? ref_mem[ak] : dflt(ak);
            e.last = (k == n - 1);
            e.due  = acc + 2 + 32'(2 * k);
            exp_q.push_back(e);
         end
         next_ok = acc + 32'(2 * n) + 2;
      end
      gap = 1'b0;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      repeat (4) @(negedge clk);
      gap = 1'b1;
   endtask

   logic [AW-1:0] pool [5];
   logic [AW-1:0] ra;

   initial begin
      pool[0] = 28'hFFFFFFE; pool[1] = 28'h0000000; pool[2] = 28'h8000000;
      pool[3] = 28'h0000123; pool[4] = 28'h7FFFFFE;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
      bus.req_wdata = '0;   bus.req_len = '0;

      repeat (5) @(posedge clk);
      #1;
      chk("rst_cs", 32'(ram_cs), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_oe", 32'(ram_oe), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

      issue(1'b1, 28'h0000123, 16'hBEEF, 4'd0);
      issue(1'b0, 28'h0000123, 16'h0000, 4'd0);
      issue(1'b1, 28'h8000000, 16'h1234, 4'd0);
      issue(1'b1, 28'h0000000, 16'h5678, 4'd0);
      issue(1'b0, 28'h8000000, 16'h0000, 4'd0);
      issue(1'b0, 28'h0000000, 16'h0000, 4'd0);
      issue(1'b1, 28'h0000040, 16'hA0A0, 4'd0);
`ifdef MEMCTL_BURST_EN
      issue(1'b1, 28'hFFFFFFE, 16'd1, 4'd0);
      issue(1'b1, 28'hFFFFFFF, 16'd2, 4'd0);
      issue(1'b1, 28'h0000000, 16'd3, 4'd0);
      issue(1'b1, 28'h0000001, 16'd4, 4'd0);
      issue(1'b0, 28'hFFFFFFE, 16'h0000, 4'd3);
`endif
      drain();

      repeat (80) begin
         ra = pool[$urandom_range(0, 4)] + AW'($urandom_range(0, 3));
         if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            gap = 1'b1;
         end
         issue(1'($urandom_range(0, 1)), ra, 16'($urandom), 4'($urandom_range(0, 15)));
      end
      drain();

      issue(1'b1, 28'h0ABCDE0, 16'h7E57, 4'd0);
      issue(1'b0, 28'h0ABCDE0, 16'h0000, 4'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("abort_cs", 32'(ram_cs), 32'd0);
      chk("abort_oe", 32'(ram_oe), 32'd0);
      chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("abort_rdata", 32'(bus.rsp_rdata), 32'd0);
      chk("abort_ready", 32'(bus.req_ready), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      gap = 1'b1;
      repeat (3) @(negedge clk);
      issue(1'b0, 28'h0ABCDE0, 16'h0000, 4'd0);
      issue(1'b1, 28'h0000200, 16'h4242, 4'd0);
      issue(1'b0, 28'h0000200, 16'h0000, 4'd0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
